// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and dispatch-side handshakes of the decode queue.
interface decode_queue_if #(parameter int PC_W = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic [9:0]      out_ctrl;
    logic            out_illegal;
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_ctrl, out_illegal
    );
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_ctrl, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding a DEPTH-entry FIFO of decoded instructions.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    decode_queue_if.slave          q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [9:0]      ctrl;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          ent_d;
    entry_t          head;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     ins;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [9:0]      ctl;
    logic [31:0]     imm;
    logic            use_rs1, use_rs2, use_rd, ill;
    logic            push, pop;

    assign ins   = q.in_instr;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // ctl bits: [9]has_imm [8]reg_write [7]alu_src [6]branch [5]jump [4]mem_read [3]mem_write [2]mem_to_reg [1:0]alu_op
    always_comb begin
        ctl     = '0;
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        ill     = 1'b0;
        case (ins[6:0])
            7'b0110011: begin ctl[8] = 1'b1; ctl[1:0] = 2'b10; {use_rs1, use_rs2, use_rd} = 3'b111; end
            7'b0010011: begin ctl[9:7] = 3'b111; ctl[1:0] = 2'b11; {use_rs1, use_rd} = 2'b11; imm = imm_i; end
            7'b0000011: begin ctl[9:7] = 3'b111; ctl[4] = 1'b1; ctl[2] = 1'b1; {use_rs1, use_rd} = 2'b11; imm = imm_i; end
            7'b0100011: begin ctl[9] = 1'b1; ctl[7] = 1'b1; ctl[3] = 1'b1; {use_rs1, use_rs2} = 2'b11; imm = imm_s; end
            7'b1100011: begin ctl[9] = 1'b1; ctl[6] = 1'b1; ctl[1:0] = 2'b01; {use_rs1, use_rs2} = 2'b11; imm = imm_b; end
            7'b1101111: begin ctl[9:8] = 2'b11; ctl[5] = 1'b1; use_rd = 1'b1; imm = imm_j; end
            7'b1100111: begin ctl[9:7] = 3'b111; ctl[5] = 1'b1; {use_rs1, use_rd} = 2'b11; imm = imm_i; end
            7'b0110111, 7'b0010111: begin ctl[9:7] = 3'b111; use_rd = 1'b1; imm = imm_u; end
            default: ill = 1'b1;
        endcase
        ent_d         = '0;
        ent_d.pc      = q.in_pc;
        ent_d.opcode  = ins[6:0];
        ent_d.funct3  = ins[14:12];
        ent_d.funct7  = ins[31:25];
        ent_d.rs1     = use_rs1 ? ins[19:15] : 5'd0;
        ent_d.rs2     = use_rs2 ? ins[24:20] : 5'd0;
        ent_d.rd      = use_rd ? ins[11:7] : 5'd0;
        ent_d.imm     = imm;
        ent_d.ctrl    = ctl;
        ent_d.ctrl[8] = ctl[8] & (|ent_d.rd);
        ent_d.illegal = ill;
    end

    assign q.in_ready  = count_q < CW'(DEPTH);
    assign q.out_valid = count_q != '0;
    assign push        = q.in_valid && q.in_ready;
    assign pop         = q.out_valid && q.out_ready;

    always_comb begin
        wptr_d  = flush ? '0 : wptr_q + AW'(push);
        rptr_d  = flush ? '0 : rptr_q + AW'(pop);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= ent_d;
    end

    assign head          = q.out_valid ? mem_q[rptr_q] : '0;
    assign q.out_pc      = head.pc;
    assign q.out_opcode  = head.opcode;
    assign q.out_funct3  = head.funct3;
    assign q.out_funct7  = head.funct7;
    assign q.out_rs1     = head.rs1;
    assign q.out_rs2     = head.rs2;
    assign q.out_rd      = head.rd;
    assign q.out_imm     = head.imm;
    assign q.out_ctrl    = head.ctrl;
    assign q.out_illegal = head.illegal;
    assign count         = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue with directed and random traffic.
module tb_decode_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

    logic clk = 0;
    logic rstn = 0;
    logic flush = 0;
    logic [2:0] count;
    int checks = 0;
    int errors = 0;
    int k;
    logic pushed;
    exp_t sb [$];
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00, 7'h7f};

    decode_queue_if #(.PC_W(32)) dq ();

    decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .q     (dq),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic r1, r2, rw;
        r1 = 0; r2 = 0; rw = 0;
        e.pc = pc; e.opc = i[6:0]; e.f3 = i[14:12]; e.f7 = i[31:25];
        e.imm = 0; e.ctrl = 0; e.ill = 0;
        case (i[6:0])
            7'h33: begin e.ctrl = 10'b0100000010; r1 = 1; r2 = 1; rw = 1; end
            7'h13: begin e.ctrl = 10'b1110000011; r1 = 1; rw = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h03: begin e.ctrl = 10'b1110010100; r1 = 1; rw = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin e.ctrl = 10'b1010001000; r1 = 1; r2 = 1; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h63: begin e.ctrl = 10'b1001000001; r1 = 1; r2 = 1; e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'h6f: begin e.ctrl = 10'b1100100000; rw = 1; e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin e.ctrl = 10'b1110100000; r1 = 1; rw = 1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h37, 7'h17: begin e.ctrl = 10'b1110000000; rw = 1; e.imm = {i[31:12], 12'h000}; end
            default: e.ill = 1;
        endcase
        e.rs1 = r1 ? i[19:15] : 0;
        e.rs2 = r2 ? i[24:20] : 0;
        e.rd  = rw ? i[11:7] : 0;
        if (e.rd == 0) e.ctrl[8] = 0;
        return e;
    endfunction

    task automatic cmp_head(input exp_t e);
        chk("pc", dq.out_pc, e.pc);
        chk("opcode", dq.out_opcode, e.opc);
        chk("funct3", dq.out_funct3, e.f3);
        chk("funct7", dq.out_funct7, e.f7);
        chk("rs1", dq.out_rs1, e.rs1);
        chk("rs2", dq.out_rs2, e.rs2);
        chk("rd", dq.out_rd, e.rd);
        chk("imm", dq.out_imm, e.imm);
        chk("ctrl", dq.out_ctrl, e.ctrl);
        chk("illegal", dq.out_illegal, e.ill);
    endtask

    // Observe the pre-edge handshake, update the scoreboard, then advance one clock.
    task automatic tick();
        #1;
        pushed = 0;
        if (rstn) begin
            chk("count", count, sb.size());
            chk("out_valid", dq.out_valid, sb.size() != 0);
            chk("in_ready", dq.in_ready, sb.size() < DEPTH);
            if (!dq.out_valid)
                chk("empty_zero", |{dq.out_pc, dq.out_opcode, dq.out_funct3, dq.out_funct7, dq.out_rs1,
                                    dq.out_rs2, dq.out_rd, dq.out_imm, dq.out_ctrl, dq.out_illegal}, 0);
            if (dq.out_valid && dq.out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else cmp_head(sb.pop_front());
            end
            if (dq.in_valid && dq.in_ready) begin
                sb.push_back(ref_dec(dq.in_instr, dq.in_pc));
                pushed = 1;
            end
            if (flush) sb.delete();
        end else sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        dq.in_valid = 1;
        dq.in_instr = instr;
        dq.in_pc    = pc;
    endtask

    initial begin
        logic [31:0] r;
        dq.in_valid = 0; dq.in_instr = 0; dq.in_pc = 0; dq.out_ready = 0;
        repeat (2) tick();
        rstn = 1;
        tick();
        chk("rst_count", count, 0);
        chk("rst_out_valid", dq.out_valid, 0);
        chk("rst_in_ready", dq.in_ready, 1);

        drive(32'hFFD08293, 32'h100);
        tick();
        dq.in_valid = 0;
        chk("addi_valid", dq.out_valid, 1);
        chk("addi_rs1", dq.out_rs1, 1);
        chk("addi_rs2", dq.out_rs2, 0);
        chk("addi_rd", dq.out_rd, 5);
        chk("addi_imm", dq.out_imm, 32'hFFFFFFFD);
        chk("addi_ctrl", dq.out_ctrl, 10'b1110000011);
        chk("addi_ill", dq.out_illegal, 0);
        chk("addi_count", count, 1);
        dq.out_ready = 1;
        tick();

        drive(32'h0021A423, 32'h104);
        tick();
        chk("sw_rd", dq.out_rd, 0);
        chk("sw_rs1", dq.out_rs1, 3);
        chk("sw_rs2", dq.out_rs2, 2);
        chk("sw_imm", dq.out_imm, 8);
        chk("sw_ctrl", dq.out_ctrl, 10'b1010001000);
        drive(32'hFE208EE3, 32'h108);
        tick();
        dq.in_valid = 0;
        chk("beq_pc", dq.out_pc, 32'h108);
        chk("beq_imm", dq.out_imm, 32'hFFFFFFFC);
        chk("beq_ctrl", dq.out_ctrl, 10'b1001000001);
        tick();
        dq.out_ready = 0;

        k = 0;
        repeat (DEPTH + 2) begin
            drive({12'(k), 5'd1, 3'b000, 5'(k + 1), 7'h13}, 32'h200 + 32'(4 * k));
            tick();
            if (pushed) k++;
        end
        chk("full_count", count, DEPTH);
        chk("full_in_ready", dq.in_ready, 0);
        chk("full_accepted", k, DEPTH);
        chk("full_head_stable", dq.out_pc, 32'h200);
        dq.out_ready = 1;
        for (int n = 0; n < 20 && (k < DEPTH + 2 || count != 0); n++) begin
            dq.in_valid = k < DEPTH + 2;
            dq.in_instr = {12'(k), 5'd1, 3'b000, 5'(k + 1), 7'h13};
            dq.in_pc    = 32'h200 + 32'(4 * k);
            tick();
            if (pushed) k++;
        end
        chk("drain_done", (k == DEPTH + 2) && (count == 0), 1);
        dq.in_valid = 0; dq.out_ready = 0;

        for (int n = 0; n < 3; n++) begin
            drive(32'h00000033 | 32'(n << 7), 32'h300 + 32'(4 * n));
            tick();
        end
        chk("pre_flush_count", count, 3);
        drive(32'h00100093, 32'h30C);
        dq.out_ready = 1;
        flush = 1;
        tick();
        flush = 0; dq.in_valid = 0; dq.out_ready = 0;
        chk("flush_count", count, 0);
        chk("flush_valid", dq.out_valid, 0);
        chk("flush_imm", dq.out_imm, 0);
        chk("flush_pc", dq.out_pc, 0);
        chk("flush_in_ready", dq.in_ready, 1);

        drive(32'h00000000, 32'h400); tick();
        drive(32'h00000093, 32'h404); tick();
        drive(32'h00000013, 32'h408); tick();
        dq.in_valid = 0;
        chk("ill_flag", dq.out_illegal, 1);
        chk("ill_ctrl", dq.out_ctrl, 0);
        dq.out_ready = 1;
        tick();
        chk("x1_regwrite", dq.out_ctrl[8], 1);
        tick();
        chk("x0_regwrite", dq.out_ctrl[8], 0);
        tick();
        dq.out_ready = 0;

        for (int n = 0; n < DEPTH; n++) begin
            drive(32'h00A00513, 32'h500 + 32'(4 * n));
            tick();
        end
        chk("pre_rst_full", dq.in_ready, 0);
        dq.out_ready = 1;
        rstn = 0;
        tick();
        rstn = 1; dq.in_valid = 0; dq.out_ready = 0;
        chk("midrst_count", count, 0);
        chk("midrst_valid", dq.out_valid, 0);
        chk("midrst_in_ready", dq.in_ready, 1);

        repeat (400) begin
            r = $urandom();
            drive({r[31:7], ops[$urandom_range(10)]}, $urandom());
            dq.in_valid  = $urandom_range(3) != 0;
            dq.out_ready = $urandom_range(2) != 0;
            flush        = $urandom_range(39) == 0;
            tick();
        end
        flush = 0; dq.in_valid = 0; dq.out_ready = 1;
        repeat (DEPTH + 1) tick();
        chk("final_empty", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Next-generation RV32I decode stage for the out-of-order front end. Each accepted instruction is fully decoded into register indices, immediate and a packed control bundle. The result is written into a parametrised FIFO that sits between fetch and rename/dispatch, with valid/ready handshakes on both sides.
Beyond the previous decoder, it adds:
- B/U/J immediates and jump control
- illegal-opcode detection
- PC carry-through
- flush
- backpressure buffering

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
PC_W, 32, width of the carried program counter.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, synchronous, active-low.
flush  input  1  synchronous queue clear (mispredict/exception).
in_valid  input  1  fetch offers instr/pc.
in_ready  output  1  queue can accept this cycle.
in_instr  input  32  raw instruction.
in_pc  input  PC_W  instruction PC.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer takes head this cycle.
out_pc  output  PC_W  head PC.
out_opcode  output  7  instr[6:0].
out_funct3  output  3  instr[14:12].
out_funct7  output  7  instr[31:25].
out_rs1  output  5  source 1 (0 if unused).
out_rs2  output  5  source 2 (0 if unused).
out_rd  output  5  destination (0 if none).
out_imm  output  32  sign-extended immediate.
out_ctrl  output  10  [9]has_imm [8]reg_write [7]alu_src [6]branch [5]jump [4]mem_read [3]mem_write [2]mem_to_reg [1:0]alu_op.
out_illegal  output  1  unsupported opcode.
count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:

Decode (combinational, on in_instr), by opcode:
- 0110011 R: alu_op=10, reg_write, rs1/rs2/rd used, imm=0.
- 0010011 I-ALU: alu_op=11, has_imm, alu_src, reg_write, rs2=0.
- 0000011 LOAD: alu_op=00, has_imm, alu_src, mem_read, mem_to_reg, reg_write, rs2=0.
- 0100011 STORE: alu_op=00, has_imm, alu_src, mem_write, rd=0, S-imm.
- 1100011 BRANCH: alu_op=01, has_imm, branch, rd=0, B-imm (bit0=0).
- 1101111 JAL: jump, has_imm, reg_write, rs1=rs2=0, J-imm (bit0=0).
- 1100111 JALR: jump, has_imm, alu_src, reg_write, rs2=0, I-imm.
- 0110111 LUI / 0010111 AUIPC: has_imm, alu_src, reg_write, rs1=rs2=0, U-imm (low 12 bits zero).
- Any other opcode: illegal=1; ctrl, rs1, rs2, rd and imm all 0; still enqueued so the exception can be ordered.

Additional decode rules:
- rd==0 forces reg_write=0.
- opcode, funct3 and funct7 are always raw bit fields, including for illegal instructions.

Queue:
- Reset (rstn=0 at an edge): read/write pointers=0, count=0, storage contents don't-care.
- in_ready = (count<DEPTH); no bypass when full.
- out_valid = (count!=0).
- Enqueue on in_valid&&in_ready.
- Dequeue on out_valid&&out_ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: an instruction enqueued at edge N appears at the head (if the queue was empty) with out_valid=1 after edge N, i.e. 1 cycle.
- Ordering is strictly FIFO.
- All out_* data fields show the head entry. While empty they are driven to 0 (out_illegal=0).
- Flush: at the edge, pointers and count go to 0; a same-cycle enqueue and dequeue are discarded. in_ready=1 in the following cycle.
- Reset has priority over flush.
- Outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then enqueue 0xFFD08293 (addi x5,x1,-3) at pc 0x100 -> next cycle out_valid=1, rs1=1, rs2=0, rd=5, imm=0xFFFFFFFD, ctrl=10'b1110000011, illegal=0, count=1.
- Enqueue 0x0021A423 (sw x2,8(x3)) and then 0xFE208EE3 (beq x1,x2,-4), out_ready=1:
  - sw: rd=0, rs1=3, rs2=2, imm=8, ctrl=10'b1010001000.
  - beq: imm=0xFFFFFFFC, ctrl=10'b1001000001.
  - Both emerge in order.
- out_ready=0, DEPTH+2 back-to-back valid inputs -> in_ready drops after 4 accepted, count=4, the head is held stable. Then out_ready=1 for 6 cycles -> the 4 entries drain in order (pointer wrap exercised) and the 2 stalled inputs follow.
- Queue holding 3 entries, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, all out fields 0, in_ready=1.
- Enqueue 0x00000000 and 0x00000093 (addi x1,x0,0, rd=1) -> first entry illegal=1 with ctrl=0; second entry reg_write=1. Then addi x0,x0,0 (0x00000013) -> reg_write=0.
- rstn=0 asserted while the queue is full and mid-handshake -> after the edge count=0, out_valid=0, in_ready=1.
